// File: rtl/serial_magnitude_comparator_pkg.sv
// serial_magnitude_comparator_pkg: FSM state encoding and default operand width
package serial_magnitude_comparator_pkg;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPARE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// serial_magnitude_comparator_if: operand request and result bundle
interface serial_magnitude_comparator_if
    import serial_magnitude_comparator_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic                         start;
    logic [WIDTH-1:0]             a_in;
    logic [WIDTH-1:0]             b_in;
    logic                         busy;
    logic                         done;
    logic                         lesser;
    logic                         greater;
    logic                         equal;
    logic [$clog2(WIDTH+1)-1:0]   cycles;
    modport master (
        output start, a_in, b_in,
        input  busy, done, lesser, greater, equal, cycles
    );
    modport slave (
        input  start, a_in, b_in,
        output busy, done, lesser, greater, equal, cycles
    );
endinterface

// File: rtl/one_bit_comparator.sv
// one_bit_comparator: combinational single-bit magnitude compare
module one_bit_comparator (
    input  logic a,
    input  logic b,
    output logic lesser,
    output logic greater,
    output logic equal
);
    assign lesser  = ~a & b;
    assign greater = a & ~b;
    assign equal   = ~(a ^ b);
endmodule

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator: MSB-first bit-serial compare of two latched operands
module serial_magnitude_comparator
    import serial_magnitude_comparator_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter bit EARLY_EXIT = 1'b1
) (
    input logic clk,
    input logic rst_n,
    serial_magnitude_comparator_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [1:0]       state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [CW-1:0]    count, cycles_q;
    logic             decided, lesser_q, greater_q, equal_q;
    logic             c_lt, c_gt, c_eq, finish;
    one_bit_comparator u_cell (
        .a       (a_sh[WIDTH-1]),
        .b       (b_sh[WIDTH-1]),
        .lesser  (c_lt),
        .greater (c_gt),
        .equal   (c_eq)
    );
    always_comb begin
        finish   = (EARLY_EXIT && !c_eq) || (count == CW'(WIDTH - 1));
        state_nx = (state == ST_IDLE)    ? (bus.start ? ST_COMPARE : ST_IDLE) :
                   (state == ST_COMPARE) ? (finish ? ST_DONE : ST_COMPARE) : ST_IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            count     <= '0;
            decided   <= 1'b0;
            lesser_q  <= 1'b0;
            greater_q <= 1'b0;
            equal_q   <= 1'b0;
            cycles_q  <= '0;
        end else if (state == ST_IDLE && bus.start) begin
            a_sh      <= bus.a_in;
            b_sh      <= bus.b_in;
            count     <= '0;
            decided   <= 1'b0;
            lesser_q  <= 1'b0;
            greater_q <= 1'b0;
            equal_q   <= 1'b0;
        end else if (state == ST_COMPARE) begin
            // only the first differing pair may set a flag
            if (!decided && !c_eq) begin
                lesser_q  <= c_lt;
                greater_q <= c_gt;
                decided   <= 1'b1;
            end
            a_sh  <= a_sh << 1;
            b_sh  <= b_sh << 1;
            count <= count + CW'(1);
            if (finish) begin
                equal_q  <= !decided && c_eq;
                cycles_q <= count + CW'(1);
            end
        end
    assign bus.busy    = (state == ST_COMPARE);
    assign bus.done    = (state == ST_DONE);
    assign bus.lesser  = lesser_q;
    assign bus.greater = greater_q;
    assign bus.equal   = equal_q;
    assign bus.cycles  = cycles_q;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb_serial_magnitude_comparator: directed scoreboard bench for early-exit and full-scan instances
module tb_serial_magnitude_comparator;
    import serial_magnitude_comparator_pkg::*;
    localparam int W  = DEF_WIDTH;
    localparam int CW = $clog2(W + 1);
    typedef struct {
        logic l;
        logic g;
        logic e;
        int   cyc;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sel = 1'b1;
    exp_t q[$];
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    serial_magnitude_comparator_if #(.WIDTH(W)) bus1 ();
    serial_magnitude_comparator_if #(.WIDTH(W)) bus0 ();
    serial_magnitude_comparator #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    serial_magnitude_comparator #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    wire          s_busy = sel ? bus1.busy    : bus0.busy;
    wire          s_done = sel ? bus1.done    : bus0.done;
    wire          s_l    = sel ? bus1.lesser  : bus0.lesser;
    wire          s_g    = sel ? bus1.greater : bus0.greater;
    wire          s_e    = sel ? bus1.equal   : bus0.equal;
    wire [CW-1:0] s_cyc  = sel ? bus1.cycles  : bus0.cycles;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // reference: first differing bit from the MSB decides; early exit stops there
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit ee);
        exp_t r;
        r = '{l: 1'b0, g: 1'b0, e: 1'b1, cyc: W};
        for (int i = W - 1; i >= 0; i--)
            if (a[i] != b[i]) begin
                r.l = b[i];
                r.g = a[i];
                r.e = 1'b0;
                if (ee) r.cyc = W - i;
                break;
            end
        return r;
    endfunction
    task automatic drive(input logic s, input logic st, input logic [W-1:0] a, input logic [W-1:0] b);
        if (s) begin bus1.start = st; bus1.a_in = a; bus1.b_in = b; end
        else   begin bus0.start = st; bus0.a_in = a; bus0.b_in = b; end
    endtask
    task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        sel = s;
        @(negedge clk);
        drive(s, 1'b1, a, b);
        q.push_back(model(a, b, s));
        @(negedge clk);
        drive(s, 1'b0, ~a, ~b);
    endtask
    task automatic wait_done(input string tag, input int exp_busy);
        int  n = 0;
        bit  seen = 0;
        exp_t e;
        for (int t = 0; t < 3 * W; t++) begin
            if (s_done) begin seen = 1; break; end
            if (s_busy) n++;
            @(negedge clk);
        end
        chk({tag, "_timeout"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_busy_cycles"}, n, exp_busy);
            chk({tag, "_busy_at_done"}, 32'(s_busy), 32'd0);
            if (q.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            else begin
                e = q.pop_front();
                chk({tag, "_lesser"}, 32'(s_l), 32'(e.l));
                chk({tag, "_greater"}, 32'(s_g), 32'(e.g));
                chk({tag, "_equal"}, 32'(s_e), 32'(e.e));
                chk({tag, "_cycles"}, 32'(s_cyc), e.cyc);
            end
            @(negedge clk);
            chk({tag, "_done_pulse"}, 32'(s_done), 32'd0);
            chk({tag, "_busy_after"}, 32'(s_busy), 32'd0);
        end
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
    initial begin
        drive(1'b1, 1'b0, '0, '0);
        drive(1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus1.busy), 0);
        chk("rst_done", 32'(bus1.done), 0);
        chk("rst_flags", {bus1.lesser, bus1.greater, bus1.equal}, 0);
        chk("rst_cycles", 32'(bus1.cycles), 0);
        chk("rst_busy0", 32'(bus0.busy), 0);
        rst_n = 1'b1;
        start_op(1'b1, 8'h3C, 8'hC3);
        wait_done("t1", 1);
        start_op(1'b1, 8'hA5, 8'hA4);
        wait_done("t2", 8);
        start_op(1'b1, 8'h5A, 8'h5A);
        wait_done("t3", 8);
        repeat (3) @(negedge clk);
        chk("t3_equal_hold", 32'(bus1.equal), 1);
        chk("t3_cycles_hold", 32'(bus1.cycles), 8);
        start_op(1'b0, 8'h80, 8'h7F);
        wait_done("t4", 8);
        start_op(1'b1, 8'h01, 8'h02);
        @(negedge clk);
        chk("t5_flags_cleared", {bus1.lesser, bus1.greater, bus1.equal}, 0);
        @(negedge clk);
        drive(1'b1, 1'b1, 8'hFF, 8'h00);
        @(negedge clk);
        drive(1'b1, 1'b0, 8'hFF, 8'h00);
        wait_done("t5", 4);
        start_op(1'b1, 8'hFF, 8'h00);
        wait_done("t5b", 1);
        start_op(1'b1, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(bus1.busy), 0);
        chk("t6_rst_flags", {bus1.lesser, bus1.greater, bus1.equal}, 0);
        chk("t6_rst_cycles", 32'(bus1.cycles), 0);
        repeat (2) begin
            @(negedge clk);
            chk("t6_rst_done", 32'(bus1.done), 0);
        end
        void'(q.pop_back());
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_idle_done", 32'(bus1.done), 0);
        start_op(1'b1, 8'h00, 8'h00);
        wait_done("t6", 8);
        chk("sb_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
